// File: rtl/bla_pkg.sv
// Shared definitions for the borrow-lookahead divider.
//   div_state_t : divider FSM states.
//   cnt_width() : bits needed to count WIDTH iterations (0..WIDTH-1), never less than 1.
package bla_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/borrow_lookahead_sub.sv
// Borrow-lookahead subtractor: difference = minuend - subtrahend - borrow_in.
// Every borrow is formed directly from the generate/propagate terms, which mirrors
// the carry-lookahead adder.
// Ports:
//   minuend, subtrahend : SIZE-bit operands.
//   borrow_in           : incoming borrow.
//   difference          : SIZE-bit result (modulo 2^SIZE).
//   borrow_out          : set when minuend < subtrahend + borrow_in.
module borrow_lookahead_sub #(
  parameter int unsigned SIZE = 9
) (
  input  logic [SIZE-1:0] minuend,
  input  logic [SIZE-1:0] subtrahend,
  input  logic            borrow_in,
  output logic [SIZE-1:0] difference,
  output logic            borrow_out
);

  logic [SIZE-1:0] gen;
  logic [SIZE-1:0] prop;
  logic [SIZE:0]   borrow;

  // Bit i generates a borrow when a=0,b=1; it passes an incoming borrow when a==b.
  assign gen  = ~minuend & subtrahend;
  assign prop = ~(minuend ^ subtrahend);

  // borrow[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]borrow_in, expanded per bit.
  always_comb begin
    logic acc;
    logic run;
    acc    = 1'b0;
    run    = 1'b0;
    borrow = '0;
    borrow[0] = borrow_in;
    for (int i = 0; i < int'(SIZE); i++) begin
      acc = gen[i];
      run = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (run & gen[j]);
        run = run & prop[j];
      end
      borrow[i+1] = acc | (run & borrow_in);
    end
  end

  assign difference = minuend ^ subtrahend ^ borrow[SIZE-1:0];
  assign borrow_out = borrow[SIZE];

endmodule

// File: rtl/bla_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset.
//   in_valid / in_ready   : operand handshake; dividend and divisor sampled on accept.
//   out_valid / out_ready : result handshake; outputs held stable while stalled.
//   quotient, remainder   : registered result, kept until the next result is ready.
//   div_by_zero           : result came from a zero divisor (quotient all ones,
//                           remainder = dividend).
module bla_divider
  import bla_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] q_sr_q, q_sr_d;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH:0]   rem_q, rem_d;       // partial remainder
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [WIDTH:0]   trial_a;
  logic [WIDTH:0]   trial_b;
  logic [WIDTH:0]   trial_diff;
  logic             trial_borrow;

  assign trial_a = {rem_q[WIDTH-1:0], q_sr_q[WIDTH-1]};
  assign trial_b = {1'b0, divisor_q};

  borrow_lookahead_sub #(
    .SIZE(WIDTH + 1)
  ) u_sub (
    .minuend   (trial_a),
    .subtrahend(trial_b),
    .borrow_in (1'b0),
    .difference(trial_diff),
    .borrow_out(trial_borrow)
  );

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    divisor_d   = divisor_q;
    q_sr_d      = q_sr_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          divisor_d  = divisor;
          q_sr_d     = dividend;
          rem_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          if (divisor == '0) begin
            // Result is known at once; out_valid is raised on the next DONE cycle.
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = CALC;
            dbz_d   = 1'b0;
          end
        end
      end

      CALC: begin
        if (trial_borrow) begin
          rem_d  = trial_a;
          q_sr_d = {q_sr_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_d  = trial_diff;
          q_sr_d = {q_sr_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          quotient_d  = q_sr_d;
          remainder_d = rem_d[WIDTH-1:0];
        end
      end

      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      divisor_q   <= '0;
      q_sr_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      divisor_q   <= divisor_d;
      q_sr_q      <= q_sr_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
    end
  end

  // The partial remainder stays below the divisor, so its top bit is always clear.
  rem_msb_zero_a: assert property (@(posedge clk) disable iff (!rst_n) rem_q[WIDTH] == 1'b0);

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_bla_divider.sv
// Self-checking bench for bla_divider at WIDTH=8: directed handshake/latency/reset
// scenarios plus randomized operands against a plain-arithmetic reference.
module tb_bla_divider;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned MaxVal = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  bla_divider #(
    .WIDTH(WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, zero divisor gives all ones / dividend.
  function automatic void ref_div(input int unsigned a, input int unsigned b,
                                  output int unsigned q, output int unsigned r,
                                  output int unsigned z);
    if (b == 0) begin
      q = MaxVal;
      r = a;
      z = 1;
    end else begin
      q = a / b;
      r = a % b;
      z = 0;
    end
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands, wait for in_ready, let the accept edge pass, drop in_valid.
  task automatic accept(input int unsigned a, input int unsigned b);
    int k;
    dividend = a[WIDTH-1:0];
    divisor  = b[WIDTH-1:0];
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!out_valid) check("result_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  // Full operation with out_ready high; checks result, flag and latency.
  task automatic run_op(input string tag, input int unsigned a, input int unsigned b);
    int unsigned eq, er, ez;
    int lat;
    ref_div(a, b, eq, er, ez);
    out_ready = 1'b1;
    accept(a, b);
    wait_result(lat);
    check({tag, "_q"}, 32'(quotient), eq);
    check({tag, "_r"}, 32'(remainder), er);
    check({tag, "_dbz"}, 32'(div_by_zero), ez);
    check({tag, "_lat"}, lat, (b == 0) ? 1 : WIDTH);
    tick();
  endtask

  initial begin
    int lat;
    int cyc, acc_n, res_n, extra;
    int acc_cyc[2];
    int hand_cyc[2];
    int unsigned res_q[2];
    int unsigned res_r[2];
    logic will_accept;
    logic busy_bad;
    int unsigned a, b;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 100/7: latency WIDTH, ready again right after the handoff edge.
    out_ready = 1'b1;
    accept(100, 7);
    wait_result(lat);
    check("t1_lat", lat, 8);
    check("t1_q", 32'(quotient), 32'd14);
    check("t1_r", 32'(remainder), 32'd2);
    check("t1_dbz", {31'd0, div_by_zero}, 32'd0);
    check("t1_busy_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("t1_handoff_valid", {31'd0, out_valid}, 32'd0);
    check("t1_ready_back", {31'd0, in_ready}, 32'd1);

    // Back-to-back 255/1 then 3/200 with in_valid held high.
    out_ready = 1'b1;
    dividend  = 8'd255;
    divisor   = 8'd1;
    in_valid  = 1'b1;
    cyc = 0; acc_n = 0; res_n = 0;
    acc_cyc  = '{0, 0};
    hand_cyc = '{0, 0};
    res_q    = '{0, 0};
    res_r    = '{0, 0};
    while (cyc < 60 && res_n < 2) begin
      if (out_valid) begin
        res_q[res_n]    = quotient;
        res_r[res_n]    = remainder;
        hand_cyc[res_n] = cyc + 1;
        res_n++;
      end
      will_accept = in_valid && in_ready;
      tick();
      cyc++;
      if (will_accept) begin
        acc_cyc[acc_n] = cyc;
        acc_n++;
        if (acc_n == 1) begin
          dividend = 8'd3;
          divisor  = 8'd200;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    extra = 0;
    repeat (12) begin
      if (out_valid) extra++;
      tick();
    end
    check("b2b_results", res_n, 2);
    check("b2b_accepts", acc_n, 2);
    check("b2b_q0", res_q[0], 32'd255);
    check("b2b_r0", res_r[0], 32'd0);
    check("b2b_q1", res_q[1], 32'd0);
    check("b2b_r1", res_r[1], 32'd3);
    check("b2b_after_handoff", {31'd0, acc_cyc[1] > hand_cyc[0]}, 32'd1);
    check("b2b_period", acc_cyc[1] - acc_cyc[0], WIDTH + 2);
    check("b2b_no_extra", extra, 0);

    // Divide by zero, then a normal op clears the flag.
    accept(5, 0);
    wait_result(lat);
    check("dz_lat", lat, 1);
    check("dz_q", 32'(quotient), 32'd255);
    check("dz_r", 32'(remainder), 32'd5);
    check("dz_flag", {31'd0, div_by_zero}, 32'd1);
    tick();
    run_op("dz_next", 9, 3);

    // 200/13 with a 5-cycle stall on the output.
    out_ready = 1'b0;
    accept(200, 13);
    wait_result(lat);
    check("stall_lat", lat, 8);
    repeat (5) begin
      tick();
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_q", 32'(quotient), 32'd15);
      check("stall_r", 32'(remainder), 32'd5);
    end
    out_ready = 1'b1;
    tick();
    check("stall_release", {31'd0, out_valid}, 32'd0);

    // 77/4 with operand noise and in_valid pulses while busy.
    out_ready = 1'b1;
    accept(77, 4);
    busy_bad = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_bad = 1'b1;
      dividend = 8'($urandom);
      divisor  = 8'($urandom);
      in_valid = ~in_valid;
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check("noise_in_ready_low", {31'd0, busy_bad}, 32'd0);
    check("noise_valid", {31'd0, out_valid}, 32'd1);
    check("noise_q", 32'(quotient), 32'd19);
    check("noise_r", 32'(remainder), 32'd1);
    tick();

    // Asynchronous reset four cycles into CALC.
    out_ready = 1'b1;
    accept(123, 5);
    repeat (4) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_q", 32'(quotient), 32'd0);
    check("arst_r", 32'(remainder), 32'd0);
    check("arst_dbz", {31'd0, div_by_zero}, 32'd0);
    repeat (2) tick();
    #2;
    rst_n = 1'b1;
    tick();
    extra = 0;
    repeat (15) begin
      if (out_valid) extra++;
      tick();
    end
    check("arst_no_stale", extra, 0);
    run_op("arst_next", 50, 6);

    // Corners, then randomized operands.
    run_op("corner_0_1", 0, 1);
    run_op("corner_255_255", 255, 255);
    run_op("corner_254_255", 254, 255);
    run_op("corner_0_0", 0, 0);
    run_op("corner_255_2", 255, 2);
    for (int i = 0; i < 2000; i++) begin
      a = $urandom_range(0, MaxVal);
      b = $urandom_range(0, MaxVal);
      case (i % 16)
        0: b = 0;
        1: b = a;
        2: b = $urandom_range(1, 3);
        3: a = $urandom_range(0, 15);
        default: ;
      endcase
      run_op("rand", a, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
